score_digit_render: RTL
=======================

Name: score_digit_render

Overview:
- APB slave holding the player score; draws it as four 7-segment style decimal digits in the VGA score area.
- Binary score is converted to BCD by a sequential double-dabble engine after each write.
- Per-pixel output `num` is computed from the VGA timing generator's current (x, y) and goes to the pixel mixer alongside the tile layer.

Parameters:
- X0, 12, left edge of digit 0 in pixels
- Y0, 12, top edge of all digits
- DIGIT_W, 24, glyph width in pixels
- DIGIT_H, 48, glyph height in pixels (even)
- GAP, 8, horizontal spacing between glyphs
- SEG_T, 4, segment stroke thickness (even, less than DIGIT_H/2)
- BLANK_LZ, 1, 1 blanks leading zeros; the least significant digit is always shown

Ports:
- PCLK  in  1  system/pixel clock
- PRESERN  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  32  APB address; only [11:0] decoded
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- x  in  10  current pixel column
- y  in  9  current pixel row
- num  out  1  registered pixel-on for score glyphs

Behaviour:
- Reset: PRESERN low asynchronously clears the following, regardless of activity:
  - score_bin = 0, digit regs = 0000, busy = 0, FSM = IDLE, num = 0.
- Write strobe: PSEL & PENABLE & PWRITE. Zero wait states.
- Register map (PADDR[11:0]):
  - 0x000 SCORE, RW. Write PWDATA[31:0]; values above 9999 saturate to 9999. Read returns {18'b0, score_bin[13:0]}.
  - 0x004 BCD, RO. Read returns {16'b0, d3,d2,d1,d0}, with d3 the most significant digit. Writes ignored.
  - 0x008 STATUS, RO. Read returns {31'b0, busy}.
  - Unmapped reads return 0. Unmapped writes are ignored.
- PRDATA is a combinational mux on PADDR, valid during PENABLE.
- Converter FSM, states IDLE and SHIFT:
  - Edge E0 (SCORE write captured): score_bin loads the saturated value, shift reg loads it, step = 0, busy = 1, state = SHIFT.
  - E1..E14: one double-dabble step per edge (add 3 to each nibble ≥5, then shift left 1).
  - E14: commit the four BCD nibbles to the digit regs atomically, busy = 0, state = IDLE.
- Display shows the old digits until the commit edge; no partial values are ever displayed.
- SCORE write while busy: reload and restart from E0 with the new value. busy stays high continuously; the interrupted value is never committed.
- Glyph regions:
  - Digit i (i = 0 leftmost = d3 … 3 = d0) spans x ∈ [X0+i·(DIGIT_W+GAP), +DIGIT_W), y ∈ [Y0, Y0+DIGIT_H).
  - Local coordinates: rx = x − left edge, ry = y − Y0.
- Segments (local coordinates):
  - a: ry < SEG_T.
  - d: ry ≥ DIGIT_H−SEG_T.
  - g: DIGIT_H/2−SEG_T/2 ≤ ry < DIGIT_H/2+SEG_T/2.
  - f: rx < SEG_T, ry < DIGIT_H/2.
  - b: rx ≥ DIGIT_W−SEG_T, ry < DIGIT_H/2.
  - e: rx < SEG_T, ry ≥ DIGIT_H/2.
  - c: rx ≥ DIGIT_W−SEG_T, ry ≥ DIGIT_H/2.
- Segment decode is standard 7-seg for 0–9; nibbles 10–15 are blank.
- Leading-zero blanking (BLANK_LZ = 1): d3 is blank if 0; d2 is blank if d3 and d2 are both 0; d1 likewise; d0 is never blanked.
- num latency: 1 cycle. num at edge N+1 reflects (x, y) and the digit regs sampled at edge N.
- num = 0 outside all glyph boxes, including the gaps between glyphs.
- Arithmetic: all region compares are done unsigned in 11 bits to avoid overflow.

Decomposition:
- Package score_pkg: register offsets (SCORE/BCD/STATUS), SCORE_MAX = 9999, 7-seg decode table (digit → abcdefg) as constants, FSM state encodings, geometry defaults.
- Sub-module bin2bcd_seq: owns the FSM, shift/add-3 datapath, busy, restart-on-load and commit.
- Top level keeps APB decode and pixel rendering.

Test Plan:
- Reset then x=120, y=13 (digit 3, segment a) → num=1 one cycle later. x=24, y=13 (blanked leading 0) → num=0. BCD reads 0x0000; STATUS reads 0.
- Write SCORE=1234 → STATUS=1 for exactly 14 cycles, then BCD=0x1234. Probe x=12, y=30 (digit 0, segment f; '1' has no f) → 0. Probe x=34, y=30 (segment b) → 1.
- Write SCORE=12000 → SCORE reads 0x270F; BCD=0x9999 after 14 cycles.
- Write 5678, then write 42 five cycles later → busy stays high continuously until 14 cycles after the second write. BCD never reads 0x5678; final BCD=0x0042; digits 0 and 1 are blanked.
- Drop PRESERN for 2 cycles mid-conversion → num, busy and BCD are 0 immediately, without waiting for a clock edge. After release, the next write converts correctly.
- Boundary probes with score 8888: x=11 → 0; x=35 → 1; x=36..43 (gap) → 0; y=59 → 1 (segment d); y=60 → 0.

Source files
------------

// File: rtl/score_digit_render_pkg.sv
// Shared constants for the score renderer: register map, saturation limit,
// converter state encodings, default glyph geometry and the 7-segment table.
package score_pkg;

  localparam logic [11:0] ADDR_SCORE  = 12'h000;
  localparam logic [11:0] ADDR_BCD    = 12'h004;
  localparam logic [11:0] ADDR_STATUS = 12'h008;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int unsigned X0_DEF      = 12;
  localparam int unsigned Y0_DEF      = 12;
  localparam int unsigned DIGIT_W_DEF = 24;
  localparam int unsigned DIGIT_H_DEF = 48;
  localparam int unsigned GAP_DEF     = 8;
  localparam int unsigned SEG_T_DEF   = 4;

  // bit order {a,b,c,d,e,f,g}; entries 10..15 are blank
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG7_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  function automatic seg7_t seg7_decode(input logic [3:0] d);
    return SEG7_LUT[d];
  endfunction

endpackage

// File: rtl/score_digit_render_if.sv
// APB bus bundle between the CPU fabric and the score renderer.
interface score_digit_render_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/score_digit_render_bin2bcd_seq.sv
// Sequential double-dabble: 14 shift steps after a load, then one atomic
// commit of all four BCD nibbles. A new load restarts the conversion.
//   state    | meaning
//   ST_IDLE  | digits hold last committed value, busy low
//   ST_SHIFT | add-3/shift in progress, cnt counts down to the commit step
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        load,
  input  logic [13:0] load_val,
  output logic        busy,
  output logic [15:0] digits
);

  logic        state;
  logic [3:0]  cnt;
  logic [29:0] sh;
  logic [29:0] adj;
  logic [29:0] sh_next;

  always_comb begin
    adj = sh;
    for (int i = 0; i < 4; i++) begin
      if (sh[14 + 4*i +: 4] >= 4'd5) adj[14 + 4*i +: 4] = sh[14 + 4*i +: 4] + 4'd3;
    end
    sh_next = {adj[28:0], 1'b0};
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sh     <= '0;
      digits <= '0;
    end else if (load) begin
      state <= ST_SHIFT;
      cnt   <= 4'd13;
      sh    <= {16'b0, load_val};
    end else if (state == ST_SHIFT) begin
      sh <= sh_next;
      if (cnt == 4'd0) begin
        digits <= sh_next[29:14];
        state  <= ST_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: rtl/score_digit_render.sv
// APB score register plus per-pixel 7-segment renderer for four decimal
// digits; num is registered one cycle after (x, y).
module score_digit_render
  import score_pkg::*;
#(
  parameter int unsigned X0       = X0_DEF,
  parameter int unsigned Y0       = Y0_DEF,
  parameter int unsigned DIGIT_W  = DIGIT_W_DEF,
  parameter int unsigned DIGIT_H  = DIGIT_H_DEF,
  parameter int unsigned GAP      = GAP_DEF,
  parameter int unsigned SEG_T    = SEG_T_DEF,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  PCLK,
  input  logic                  PRESERN,
  score_digit_render_if.slave   apb,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  output logic                  num
);

  localparam logic [10:0] X11   = 11'(X0);
  localparam logic [10:0] Y11   = 11'(Y0);
  localparam logic [10:0] W11   = 11'(DIGIT_W);
  localparam logic [10:0] H11   = 11'(DIGIT_H);
  localparam logic [10:0] T11   = 11'(SEG_T);
  localparam logic [10:0] HALF  = 11'(DIGIT_H / 2);
  localparam logic [10:0] HT11  = 11'(SEG_T / 2);
  localparam logic [10:0] PITCH = 11'(DIGIT_W + GAP);

  logic [13:0] score_bin;
  logic [13:0] sat_val;
  logic        load;
  logic        busy;
  logic [15:0] digits;

  assign load    = apb.PSEL && apb.PENABLE && apb.PWRITE && (apb.PADDR[11:0] == ADDR_SCORE);
  assign sat_val = (apb.PWDATA > {18'b0, SCORE_MAX}) ? SCORE_MAX : apb.PWDATA[13:0];

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) score_bin <= '0;
    else if (load) score_bin <= sat_val;
  end

  bin2bcd_seq u_bcd (
    .PCLK     (PCLK),
    .PRESERN  (PRESERN),
    .load     (load),
    .load_val (sat_val),
    .busy     (busy),
    .digits   (digits)
  );

  always_comb begin
    apb.PRDATA = '0;
    case (apb.PADDR[11:0])
      ADDR_SCORE:  apb.PRDATA = {18'b0, score_bin};
      ADDR_BCD:    apb.PRDATA = {16'b0, digits};
      ADDR_STATUS: apb.PRDATA = {31'b0, busy};
      default:     apb.PRDATA = '0;
    endcase
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  logic [10:0] xx, yy, left, rx, ry;
  logic [3:0]  blank;
  logic [3:0]  nib;
  seg7_t       segs, hit;
  logic        in_box, pix_on;

  assign xx = {1'b0, x};
  assign yy = {2'b0, y};

  // display slot 0 is the most significant digit; slot 3 is never blanked
  always_comb begin
    blank[0] = BLANK_LZ && (digits[15:12] == 4'd0);
    blank[1] = blank[0] && (digits[11:8] == 4'd0);
    blank[2] = blank[1] && (digits[7:4] == 4'd0);
    blank[3] = 1'b0;
    pix_on = 1'b0;
    left   = '0;
    nib    = '0;
    segs   = '0;
    hit    = '0;
    in_box = 1'b0;
    rx     = '0;
    ry     = '0;
    for (int i = 0; i < 4; i++) begin
      left   = X11 + 11'(i) * PITCH;
      nib    = digits[15 - 4*i -: 4];
      segs   = blank[i] ? 7'b0 : seg7_decode(nib);
      in_box = (xx >= left) && (xx < left + W11) && (yy >= Y11) && (yy < Y11 + H11);
      rx     = xx - left;
      ry     = yy - Y11;
      hit[6] = (ry < T11);
      hit[5] = (rx >= W11 - T11) && (ry < HALF);
      hit[4] = (rx >= W11 - T11) && (ry >= HALF);
      hit[3] = (ry >= H11 - T11);
      hit[2] = (rx < T11) && (ry >= HALF);
      hit[1] = (rx < T11) && (ry < HALF);
      hit[0] = (ry >= HALF - HT11) && (ry < HALF + HT11);
      if (in_box && |(segs & hit)) pix_on = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) num <= 1'b0;
    else num <= pix_on;
  end

endmodule
